mem_port_arbiter: RTL and testbench

- Shares the single byte-addressed, 32-bit little-endian data memory port between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Serialises accesses and sequences the memory strobes for its one-cycle registered read latency.
- Rejects misaligned or out-of-range word accesses before they reach memory.
- Sits between the core pipeline and the memory block.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, port ids and the word-address legality check used by the
// data-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   // A 32-bit unsigned compare, so addresses with upper bits set can never alias into memory.
   function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_bytes);
      logic [31:0] limit_s;
      limit_s = 32'(mem_bytes) - 32'd4;
      return (addr[1:0] == 2'b00) && (addr <= limit_s);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant selector: round-robin or fixed LS priority
// when both requesters are active.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int RR_MODE = 1
) (
   input  logic if_req,
   input  logic ls_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   // Select the winner among the active requesters
   always_comb begin
      grant_valid = if_req | ls_req;
      grant_id    = PORT_IF;
      if (if_req && ls_req) begin
         if (RR_MODE != 0) begin
            grant_id = ~last_grant;
         end else begin
            grant_id = PORT_LS;
         end
      end else if (ls_req) begin
         grant_id = PORT_LS;
      end else begin
         grant_id = PORT_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the
// load/store unit, sequencing strobes around the registered read latency.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_BYTES = 64,
   parameter int RR_MODE   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ack,
   output logic        ls_err,
   output logic [31:0] ls_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_ren,
   output logic        mem_wen,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   arb_state_t  state_r;
   arb_state_t  state_s;
   logic        last_grant_r;
   logic        winner_r;
   logic        we_r;
   logic        err_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        grant_valid_s;
   logic        grant_id_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic        sel_we_s;
   logic        sel_legal_s;
   logic        resp_ok_s;

   mem_arb_pick #(.RR_MODE(RR_MODE)) u_pick (
      .if_req      (if_req),
      .ls_req      (ls_req),
      .last_grant  (last_grant_r),
      .grant_valid (grant_valid_s),
      .grant_id    (grant_id_s)
   );

   // Route the winning requester's command toward the latches
   always_comb begin
      if (grant_id_s == PORT_LS) begin
         sel_addr_s  = ls_addr;
         sel_wdata_s = ls_wdata;
         sel_we_s    = ls_we;
      end else begin
         sel_addr_s  = if_addr;
         sel_wdata_s = 32'd0;
         sel_we_s    = 1'b0;
      end
      sel_legal_s = addr_legal(sel_addr_s, MEM_BYTES);
   end

   // Next-state logic; rejected accesses skip ISSUE so memory never sees them
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               if (sel_legal_s) begin
                  state_s = ISSUE;
               end else begin
                  state_s = RESP;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE:   state_s = RESP;
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and command latches, loaded only when a grant is taken in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         last_grant_r <= PORT_IF;
         winner_r     <= PORT_IF;
         we_r         <= 1'b0;
         err_r        <= 1'b0;
         addr_r       <= 32'd0;
         wdata_r      <= 32'd0;
      end else begin
         state_r <= state_s;
         if ((state_r == IDLE) && grant_valid_s) begin
            winner_r     <= grant_id_s;
            last_grant_r <= grant_id_s;
            addr_r       <= sel_addr_s;
            wdata_r      <= sel_wdata_s;
            we_r         <= sel_we_s;
            err_r        <= ~sel_legal_s;
         end else begin
            winner_r     <= winner_r;
            last_grant_r <= last_grant_r;
            addr_r       <= addr_r;
            wdata_r      <= wdata_r;
            we_r         <= we_r;
            err_r        <= err_r;
         end
      end
   end

   // Output decode from registered state; strobes are masked by reset so an aborted write never lands
   always_comb begin
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      if_ack    = 1'b0;
      if_err    = 1'b0;
      if_rdata  = 32'd0;
      ls_ack    = 1'b0;
      ls_err    = 1'b0;
      ls_rdata  = 32'd0;
      resp_ok_s = (state_r == RESP) && !err_r && !we_r;
      busy      = (state_r != IDLE);
      if (state_r == ISSUE) begin
         mem_addr  = addr_r;
         mem_wdata = wdata_r;
         mem_ren   = ~we_r & ~reset;
         mem_wen   = we_r & ~reset;
      end else begin
         mem_addr  = 32'd0;
         mem_wdata = 32'd0;
      end
      if (state_r == RESP) begin
         if (winner_r == PORT_LS) begin
            ls_ack   = 1'b1;
            ls_err   = err_r;
            ls_rdata = resp_ok_s ? mem_rdata : 32'd0;
         end else begin
            if_ack   = 1'b1;
            if_err   = err_r;
            if_rdata = resp_ok_s ? mem_rdata : 32'd0;
         end
      end else begin
         ls_ack = 1'b0;
         if_ack = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// single-port traffic, checked against a transaction-level model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;

   logic        if_ack, if_err, ls_ack, ls_err, mem_ren, mem_wen, busy;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'd0;

   logic        if_ack1, if_err1, ls_ack1, ls_err1, mem_ren1, mem_wen1, busy1;
   logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1;
   logic [31:0] mem_rdata1 = 32'd0;

   logic [31:0] mem0 [0:15] = '{default: 32'd0};
   logic [31:0] mem1 [0:15] = '{default: 32'd0};

   // Reference model state
   logic [31:0] sb [0:15] = '{default: 32'd0};
   logic        model_last = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_BYTES(64), .RR_MODE(1)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_err(ls_err), .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.MEM_BYTES(64), .RR_MODE(0)) dut_fp (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1), .if_err(if_err1), .if_rdata(if_rdata1),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack1), .ls_err(ls_err1), .ls_rdata(ls_rdata1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ren(mem_ren1), .mem_wen(mem_wen1),
      .mem_rdata(mem_rdata1), .busy(busy1)
   );

   // Synchronous memories with one-cycle registered read data
   always @(posedge clk) begin
      if (mem_wen) mem0[mem_addr[5:2]] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem0[mem_addr[5:2]];
      if (mem_wen1) mem1[mem_addr1[5:2]] <= mem_wdata1;
      if (mem_ren1) mem_rdata1 <= mem1[mem_addr1[5:2]];
   end

   function automatic bit m_legal(input logic [31:0] a);
      return ((a % 32'd4) == 32'd0) && ((64'(a) + 64'd4) <= 64'd64);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One single-port transaction, requested in IDLE, checked end to end
   task automatic do_txn(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bit          legal;
      bit          seen;
      int          lat, rens, wens, both, others;
      logic        got_err;
      logic [31:0] got_rdata, strobe_addr, exp_rdata;
      legal = m_legal(addr);
      exp_rdata = (legal && !we) ? sb[addr[5:2]] : 32'd0;
      seen = 1'b0; lat = 0; rens = 0; wens = 0; both = 0; others = 0;
      got_err = 1'b0; got_rdata = 32'd0; strobe_addr = 32'd0;
      if (port) begin
         ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; if_req = 1'b0;
      end else begin
         if_req = 1'b1; if_addr = addr; ls_req = 1'b0;
      end
      for (int k = 1; k <= 6 && !seen; k++) begin
         @(negedge clk);
         if (mem_ren) begin rens++; strobe_addr = mem_addr; end
         if (mem_wen) begin wens++; strobe_addr = mem_addr; end
         if (mem_ren && mem_wen) both++;
         if (port ? if_ack : ls_ack) others++;
         if (port ? ls_ack : if_ack) begin
            seen = 1'b1; lat = k;
            got_err   = port ? ls_err : if_err;
            got_rdata = port ? ls_rdata : if_rdata;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
      if (mem_ren) rens++;
      if (mem_wen) wens++;
      check("ack_seen", 32'(seen), 32'd1);
      check("ack_latency", 32'(lat), legal ? 32'd2 : 32'd1);
      check("err", 32'(got_err), legal ? 32'd0 : 32'd1);
      check("rdata", got_rdata, exp_rdata);
      check("other_ack", 32'(others), 32'd0);
      check("ren_cycles", 32'(rens), (legal && !we) ? 32'd1 : 32'd0);
      check("wen_cycles", 32'(wens), (legal && we) ? 32'd1 : 32'd0);
      check("strobe_excl", 32'(both), 32'd0);
      if (legal) check("strobe_addr", strobe_addr, addr);
      if (legal && we) sb[addr[5:2]] = wdata;
      model_last = port;
   endtask

   initial begin
      logic        exp_port;
      logic        lg;
      int          acks;
      logic [31:0] ren_addrs [$];

      reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
      check("rst_errs", {30'd0, if_err, ls_err}, 32'd0);
      check("rst_rdata", if_rdata | ls_rdata, 32'd0);
      check("rst_mem", mem_addr | mem_wdata, 32'd0);
      check("rst_strobes_busy", {29'd0, mem_ren, mem_wen, busy}, 32'd0);
      reset = 1'b0;
      model_last = 1'b0;
      @(negedge clk);

      // LS write then read back
      do_txn(1'b1, 1'b1, 32'd8, 32'hDEAD_BEEF);
      do_txn(1'b1, 1'b0, 32'd8, 32'd0);

      // Illegal and boundary addresses
      do_txn(1'b0, 1'b0, 32'h0000_0002, 32'd0);
      do_txn(1'b0, 1'b0, 32'd60, 32'd0);
      do_txn(1'b0, 1'b0, 32'd61, 32'd0);
      do_txn(1'b0, 1'b0, 32'h0000_0100, 32'd0);
      do_txn(1'b0, 1'b0, 32'd64, 32'd0);
      do_txn(1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0);
      do_txn(1'b1, 1'b1, 32'h0000_0048, 32'h1234_5678);
      do_txn(1'b1, 1'b1, 32'h8000_0008, 32'h1234_5678);
      do_txn(1'b1, 1'b0, 32'd8, 32'd0);

      // Simultaneous held requests: legal reads take 3 cycles each
      if_addr = 32'd8; ls_addr = 32'd8; ls_we = 1'b0;
      if_req = 1'b1; ls_req = 1'b1;
      lg = model_last;
      exp_port = ~lg;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if ((k % 3) == 0) begin
            lg = exp_port;
            exp_port = ~lg;
         end
         check("rr_if_ack", 32'(if_ack), ((k % 3) == 2 && exp_port == 1'b0) ? 32'd1 : 32'd0);
         check("rr_ls_ack", 32'(ls_ack), ((k % 3) == 2 && exp_port == 1'b1) ? 32'd1 : 32'd0);
         check("fp_if_ack", 32'(if_ack1), 32'd0);
         check("fp_ls_ack", 32'(ls_ack1), ((k % 3) == 2) ? 32'd1 : 32'd0);
         if ((k % 3) == 2) begin
            check("rr_rdata", if_rdata | ls_rdata, sb[2]);
            check("fp_rdata", ls_rdata1 | if_rdata1, sb[2]);
            check("fp_errs", {30'd0, if_err1, ls_err1}, 32'd0);
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      model_last = exp_port;
      @(negedge clk);
      check("idle_after_rr", {30'd0, busy, busy1}, 32'd0);

      // Reset during the ISSUE cycle of a write
      do_txn(1'b1, 1'b1, 32'd12, 32'h1111_2222);
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd12; ls_wdata = 32'h3333_4444;
      @(negedge clk);
      check("issue_wen", 32'(mem_wen), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_ack", 32'(ls_ack), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      reset = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      model_last = 1'b0;
      @(negedge clk);
      check("abort_ack2", {30'd0, ls_ack, if_ack}, 32'd0);
      do_txn(1'b1, 1'b0, 32'd12, 32'd0);

      // Random single-port traffic
      for (int i = 0; i < 30; i++) begin
         logic        p, w;
         logic [31:0] a;
         p = 1'($urandom_range(0, 1));
         w = p ? 1'($urandom_range(0, 1)) : 1'b0;
         if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 15)) * 32'd4;
         else a = $urandom;
         do_txn(p, w, a, $urandom);
      end

      // Back-to-back LS reads with the address changed at the ack
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd0;
      acks = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mem_ren) ren_addrs.push_back(mem_addr);
         if (ls_ack) begin
            acks++;
            if (acks == 1) begin
               check("b2b_lat1", 32'(k), 32'd2);
               check("b2b_rdata1", ls_rdata, sb[0]);
               ls_addr = 32'd4;
            end else begin
               check("b2b_lat2", 32'(k), 32'd5);
               check("b2b_rdata2", ls_rdata, sb[1]);
               ls_req = 1'b0;
            end
         end
      end
      ls_req = 1'b0;
      check("b2b_acks", 32'(acks), 32'd2);
      check("b2b_ren_count", 32'(ren_addrs.size()), 32'd2);
      if (ren_addrs.size() == 2) begin
         check("b2b_addr0", ren_addrs[0], 32'd0);
         check("b2b_addr1", ren_addrs[1], 32'd4);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
